// File: rtl/mic_level_meter.sv
// mic_level_meter: quantises the filtered mic peak to a 0..16 level with meter ballistics, bar graph and BCD.
// Optional `define MIC_METER_PEAK_HOLD_EN builds the held peak marker (PEAK_LEVEL, LED marker).
module mic_level_meter #(
    parameter int UPDATE_DIV   = 1000,
    parameter int NOISE_FLOOR  = 2048,
    parameter int STEP_SHIFT   = 7,
    parameter int HOLD_UPDATES = 10
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [11:0] MIC_LEVEL,
    output logic [15:0] LED,
    output logic [4:0]  LEVEL,
    output logic [4:0]  PEAK_LEVEL,
    output logic [3:0]  BCD_TENS,
    output logic [3:0]  BCD_ONES,
    output logic        UPDATE
);
    localparam int DW = $clog2(UPDATE_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(UPDATE_DIV - 1);
    localparam logic [11:0] FLOOR = 12'(NOISE_FLOOR);
    typedef enum logic [1:0] {WAIT, QUANT, BALLISTIC, PUBLISH} state_t;
    if (UPDATE_DIV < 4 || HOLD_UPDATES < 0) begin : g_param_check
        $error("mic_level_meter: UPDATE_DIV must be >= 4 and HOLD_UPDATES >= 0");
    end
    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [11:0]   sample_r;
    logic [11:0]   diff;
    logic [11:0]   shifted;
    logic [4:0]    raw;
    logic [4:0]    raw_q;
    logic [4:0]    disp;
    logic [4:0]    disp_n;
    logic [15:0]   therm;
    logic [15:0]   led_n;
    assign diff    = sample_r - FLOOR;
    assign shifted = diff >> STEP_SHIFT;
    // saturate at 16 before narrowing so large steps cannot wrap in 5 bits
    assign raw     = sample_r <= FLOOR ? 5'd0 : shifted > 12'd16 ? 5'd16 : shifted[4:0];
    assign disp_n  = raw_q >= disp ? raw_q : disp - 5'd1;
    assign therm   = 16'((17'd1 << disp) - 17'd1);
`ifdef MIC_METER_PEAK_HOLD_EN
    localparam int HW = $clog2(HOLD_UPDATES + 2);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_UPDATES);
    logic [4:0]    peak;
    logic [HW-1:0] hold;
    assign led_n = therm | (peak != 5'd0 ? 16'd1 << (peak - 5'd1) : 16'd0);
`else
    assign led_n      = therm;
    assign PEAK_LEVEL = 5'd0;
`endif
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= WAIT;
            div_cnt  <= '0;
            sample_r <= '0;
            raw_q    <= '0;
            disp     <= '0;
            LED      <= '0;
            LEVEL    <= '0;
            BCD_TENS <= '0;
            BCD_ONES <= '0;
            UPDATE   <= 1'b0;
`ifdef MIC_METER_PEAK_HOLD_EN
            peak       <= '0;
            hold       <= '0;
            PEAK_LEVEL <= '0;
`endif
        end else begin
            div_cnt <= div_cnt == DIV_LAST ? '0 : div_cnt + DW'(1);
            UPDATE  <= 1'b0;
            case (state)
                WAIT: begin
                    if (div_cnt == DIV_LAST) begin
                        sample_r <= MIC_LEVEL;
                        state    <= QUANT;
                    end
                end
                QUANT: begin
                    raw_q <= raw;
                    state <= BALLISTIC;
                end
                BALLISTIC: begin
                    disp <= disp_n;
`ifdef MIC_METER_PEAK_HOLD_EN
                    if (disp_n >= peak) begin
                        peak <= disp_n;
                        hold <= HOLD_INIT;
                    end else if (hold != '0) begin
                        hold <= hold - HW'(1);
                    end else if (peak != 5'd0) begin
                        peak <= peak - 5'd1;
                    end
`endif
                    state <= PUBLISH;
                end
                PUBLISH: begin
                    LED      <= led_n;
                    LEVEL    <= disp;
                    BCD_TENS <= disp >= 5'd10 ? 4'd1 : 4'd0;
                    BCD_ONES <= 4'(disp >= 5'd10 ? disp - 5'd10 : disp);
                    UPDATE   <= 1'b1;
`ifdef MIC_METER_PEAK_HOLD_EN
                    PEAK_LEVEL <= peak;
`endif
                    state <= WAIT;
                end
                default: state <= WAIT;
            endcase
        end
    end
endmodule
